bunki_pred: RTL and testbench

BUNKI_PRED -- requirements
Module: bunki_pred

---
 rtl/bunki_pred.sv | 87 ++++++++
 tb/tb_bunki_pred.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bunki_pred.sv
// bunki_pred: 2-bit saturating-counter branch predictor with next-PC selection, mispredict flush and miss counter.
// Optional gshare indexing is enabled by defining BUNKI_PRED_GSHARE_EN.
module bunki_pred #(
    parameter int PC_W  = 12,
    parameter int IDX_W = 4,
    parameter int OFS_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [PC_W-1:0]  f_pc,
    input  logic             f_br,
    input  logic             f_jmp,
    input  logic [OFS_W-1:0] f_ofs,
    output logic [1:0]       f_pred,
    output logic [IDX_W-1:0] f_idx,
    output logic [PC_W-1:0]  next_pc,
    input  logic             r_valid,
    input  logic [IDX_W-1:0] r_idx,
    input  logic [PC_W-1:0]  r_pc,
    input  logic [OFS_W-1:0] r_ofs,
    input  logic             r_taken,
    input  logic             r_pred,
    input  logic [1:0]       r_depth,
    output logic [1:0]       flush,
    output logic [15:0]      miss_cnt
);
    logic [1:0]      r_table [2**IDX_W];
    logic [15:0]     r_miss;
    logic            w_miss;
    logic [1:0]      w_f_ctr;
    logic [1:0]      w_r_ctr;
    logic [1:0]      w_r_upd;
    logic [PC_W-1:0] w_f_tgt;
    logic [PC_W-1:0] w_r_tgt;

`ifdef BUNKI_PRED_GSHARE_EN
    logic [IDX_W-1:0] r_hist;
    assign f_idx = f_pc[IDX_W-1:0] ^ r_hist;
    // Global history shifts in each resolved outcome at its lsb
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_hist <= '0;
        else if (enable && r_valid)
            r_hist <= {r_hist[IDX_W-2:0], r_taken};
    end
`else
    assign f_idx = f_pc[IDX_W-1:0];
`endif

    // Prediction, target arithmetic (wraps modulo 2**PC_W) and next-PC priority select
    always_comb begin
        w_miss  = r_valid & (r_taken != r_pred);
        w_f_ctr = r_table[f_idx];
        w_r_ctr = r_table[r_idx];
        w_r_upd = r_taken ? ((w_r_ctr == 2'b11) ? 2'b11 : w_r_ctr + 2'd1)
                          : ((w_r_ctr == 2'b00) ? 2'b00 : w_r_ctr - 2'd1);
        w_f_tgt = f_pc + {{(PC_W-OFS_W){f_ofs[OFS_W-1]}}, f_ofs} + PC_W'(1);
        w_r_tgt = r_pc + {{(PC_W-OFS_W){r_ofs[OFS_W-1]}}, r_ofs} + PC_W'(1);
        f_pred  = (f_br && !f_jmp && !w_miss) ? {w_f_ctr[1], ~w_f_ctr[1]} : 2'b00;
        flush   = w_miss ? r_depth : 2'b00;
        next_pc = w_miss ? (r_taken ? w_r_tgt : r_pc + PC_W'(1))
                : f_jmp ? w_f_tgt
                : (f_br && w_f_ctr[1]) ? w_f_tgt
                : f_pc + PC_W'(1);
    end

    // Counter table trains on each enabled resolve; reads see the pre-update value
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2**IDX_W; i++)
                r_table[i] <= 2'b00;
        end else if (enable && r_valid) begin
            r_table[r_idx] <= w_r_upd;
        end
    end

    // Saturating mispredict counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_miss <= '0;
        else if (enable && w_miss && !(&r_miss))
            r_miss <= r_miss + 16'd1;
    end

    assign miss_cnt = r_miss;
endmodule

// File: tb/tb_bunki_pred.sv
// tb_bunki_pred: scoreboard bench for bunki_pred with directed vectors and hand-computed expectations.
module tb_bunki_pred;
    logic        clock = 0;
    logic        reset = 0;
    logic        enable = 1;
    logic [11:0] f_pc = 0;
    logic        f_br = 0;
    logic        f_jmp = 0;
    logic [7:0]  f_ofs = 0;
    logic [1:0]  f_pred;
    logic [3:0]  f_idx;
    logic [11:0] next_pc;
    logic        r_valid = 0;
    logic [3:0]  r_idx = 0;
    logic [11:0] r_pc = 0;
    logic [7:0]  r_ofs = 0;
    logic        r_taken = 0;
    logic        r_pred = 0;
    logic [1:0]  r_depth = 0;
    logic [1:0]  flush;
    logic [15:0] miss_cnt;

    typedef struct {
        string       name;
        logic [1:0]  pred;
        logic [3:0]  idx;
        logic [11:0] npc;
        logic [1:0]  fl;
        logic [15:0] miss;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    bunki_pred dut (
        .clock(clock), .reset(reset), .enable(enable),
        .f_pc(f_pc), .f_br(f_br), .f_jmp(f_jmp), .f_ofs(f_ofs),
        .f_pred(f_pred), .f_idx(f_idx), .next_pc(next_pc),
        .r_valid(r_valid), .r_idx(r_idx), .r_pc(r_pc), .r_ofs(r_ofs),
        .r_taken(r_taken), .r_pred(r_pred), .r_depth(r_depth),
        .flush(flush), .miss_cnt(miss_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string n, input string f, input logic [15:0] a, input logic [15:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", n, f, a, e);
        end
    endtask

    // Monitor: compare each presented output set against the oldest expectation
    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "f_pred", 16'(f_pred), 16'(e.pred));
            chk(e.name, "f_idx", 16'(f_idx), 16'(e.idx));
            chk(e.name, "next_pc", 16'(next_pc), 16'(e.npc));
            chk(e.name, "flush", 16'(flush), 16'(e.fl));
            chk(e.name, "miss_cnt", miss_cnt, e.miss);
        end
    end

    task automatic vec(input string n, input logic en,
                       input logic [11:0] pc, input logic br, input logic jmp, input logic [7:0] ofs,
                       input logic rv, input logic [3:0] ri, input logic [11:0] rp, input logic [7:0] ro,
                       input logic rt, input logic rpr, input logic [1:0] rd,
                       input logic [1:0] ep, input logic [3:0] ei, input logic [11:0] en_pc,
                       input logic [1:0] ef, input logic [15:0] em);
        exp_t e;
        @(posedge clock);
        #1;
        enable = en; f_pc = pc; f_br = br; f_jmp = jmp; f_ofs = ofs;
        r_valid = rv; r_idx = ri; r_pc = rp; r_ofs = ro; r_taken = rt; r_pred = rpr; r_depth = rd;
        e.name = n; e.pred = ep; e.idx = ei; e.npc = en_pc; e.fl = ef; e.miss = em;
        q.push_back(e);
    endtask

    task automatic idle();
        enable = 1; f_br = 0; f_jmp = 0; r_valid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 0;
`ifdef BUNKI_PRED_GSHARE_EN
        #12 reset = 1;
        vec("gs_h0", 1, 12'h000, 0, 0, 8'h00, 1, 4'h0, 12'h000, 8'h00, 1, 1, 2'b01, 2'b00, 4'h0, 12'h001, 2'b00, 0);
        vec("gs_h1", 1, 12'h000, 0, 0, 8'h00, 1, 4'h0, 12'h000, 8'h00, 1, 1, 2'b01, 2'b00, 4'h1, 12'h001, 2'b00, 0);
        vec("gs_h3", 1, 12'h005, 0, 0, 8'h00, 0, 4'h0, 12'h000, 8'h00, 0, 0, 2'b00, 2'b00, 4'h6, 12'h006, 2'b00, 0);
`else
        vec("rst_state", 1, 12'h005, 1, 0, 8'h03, 0, 4'h0, 12'h000, 8'h00, 0, 0, 2'b00, 2'b01, 4'h5, 12'h006, 2'b00, 0);
        @(negedge clock);
        #2 reset = 1;
        vec("cold_pred", 1, 12'h005, 1, 0, 8'h03, 0, 4'h0, 12'h000, 8'h00, 0, 0, 2'b00, 2'b01, 4'h5, 12'h006, 2'b00, 0);
        vec("miss_t1", 1, 12'h005, 1, 0, 8'h03, 1, 4'h5, 12'h010, 8'h04, 1, 0, 2'b10, 2'b00, 4'h5, 12'h015, 2'b10, 0);
        vec("miss_t2", 1, 12'h005, 1, 0, 8'h03, 1, 4'h5, 12'h010, 8'h04, 1, 0, 2'b10, 2'b00, 4'h5, 12'h015, 2'b10, 1);
        vec("warm_pred", 1, 12'h005, 1, 0, 8'h03, 0, 4'h0, 12'h000, 8'h00, 0, 0, 2'b00, 2'b10, 4'h5, 12'h009, 2'b00, 2);
        vec("miss_vs_jmp", 1, 12'h020, 0, 1, 8'h10, 1, 4'h3, 12'h0FF, 8'h80, 1, 0, 2'b01, 2'b00, 4'h0, 12'h080, 2'b01, 2);
        vec("jmp_wrap", 1, 12'hFFF, 0, 1, 8'h01, 0, 4'h0, 12'h000, 8'h00, 0, 0, 2'b00, 2'b00, 4'hF, 12'h001, 2'b00, 3);
        vec("miss_nt", 1, 12'h100, 1, 0, 8'h05, 1, 4'h5, 12'h200, 8'h10, 0, 1, 2'b10, 2'b00, 4'h0, 12'h201, 2'b10, 3);
        vec("after_dec", 1, 12'h105, 1, 0, 8'hFE, 0, 4'h0, 12'h000, 8'h00, 0, 0, 2'b00, 2'b01, 4'h5, 12'h106, 2'b00, 4);
        vec("stall_miss", 0, 12'h005, 1, 0, 8'h03, 1, 4'h5, 12'h000, 8'h00, 1, 0, 2'b10, 2'b00, 4'h5, 12'h001, 2'b10, 4);
        vec("after_stall", 1, 12'h005, 1, 0, 8'h03, 0, 4'h0, 12'h000, 8'h00, 0, 0, 2'b00, 2'b01, 4'h5, 12'h006, 2'b00, 4);
        vec("rbw_hit", 1, 12'h005, 1, 0, 8'h03, 1, 4'h5, 12'h300, 8'h00, 1, 1, 2'b10, 2'b01, 4'h5, 12'h006, 2'b00, 4);
        vec("neg_ofs", 1, 12'h005, 1, 0, 8'hFD, 0, 4'h0, 12'h000, 8'h00, 0, 0, 2'b00, 2'b10, 4'h5, 12'h003, 2'b00, 4);
        vec("br_and_jmp", 1, 12'h005, 1, 1, 8'h02, 0, 4'h0, 12'h000, 8'h00, 0, 0, 2'b00, 2'b00, 4'h5, 12'h008, 2'b00, 4);
        vec("inc_to_3", 1, 12'h010, 0, 0, 8'h00, 1, 4'h5, 12'h000, 8'h00, 1, 1, 2'b01, 2'b00, 4'h0, 12'h011, 2'b00, 4);
        vec("sat_hi", 1, 12'h010, 0, 0, 8'h00, 1, 4'h5, 12'h000, 8'h00, 1, 1, 2'b01, 2'b00, 4'h0, 12'h011, 2'b00, 4);
        vec("dec_from_3", 1, 12'h010, 0, 0, 8'h00, 1, 4'h5, 12'h000, 8'h00, 0, 0, 2'b01, 2'b00, 4'h0, 12'h011, 2'b00, 4);
        vec("sat_check", 1, 12'h005, 1, 0, 8'h03, 0, 4'h0, 12'h000, 8'h00, 0, 0, 2'b00, 2'b10, 4'h5, 12'h009, 2'b00, 4);
        vec("pre_reset", 1, 12'h0F0, 1, 0, 8'h10, 1, 4'h5, 12'h400, 8'h20, 0, 1, 2'b01, 2'b00, 4'h0, 12'h401, 2'b01, 4);
        @(negedge clock);
        #1 reset = 0;
        idle();
        @(posedge clock);
        #2 reset = 1;
        vec("post_reset", 1, 12'h005, 1, 0, 8'h03, 0, 4'h0, 12'h000, 8'h00, 0, 0, 2'b00, 2'b01, 4'h5, 12'h006, 2'b00, 0);
`endif
        @(posedge clock);
        #1 idle();
        repeat (2) @(posedge clock);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
